// File: rtl/axis_flit_tx_if.sv
// AXI-Stream beat channel feeding axis_flit_tx; master drives the beat, slave returns tready.
interface axis_flit_tx_if #(
  parameter int TDATA_WIDTH = 128,
  parameter int DEST_WIDTH  = 4
);
  logic                   axis_tvalid;
  logic                   axis_tready;
  logic [TDATA_WIDTH-1:0] axis_tdata;
  logic                   axis_tlast;
  logic [DEST_WIDTH-1:0]  axis_tdest;

  modport master (
    output axis_tvalid, axis_tdata, axis_tlast, axis_tdest,
    input  axis_tready
  );

  modport slave (
    input  axis_tvalid, axis_tdata, axis_tlast, axis_tdest,
    output axis_tready
  );
endinterface

// File: rtl/axis_flit_tx.sv
// AXIS-to-NoC flit serializer with credit-based flow control (one beat held, LSB flit first).
// Optional statistics (flit_count, credit_err) are enabled by defining AXIS_FLIT_TX_STATS_EN.
module axis_flit_tx #(
  parameter int TDATA_WIDTH          = 128,
  parameter int DEST_WIDTH           = 4,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_BUFFER_DEPTH    = 1,
  localparam int FLIT_WIDTH          = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int CW                  = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  axis_flit_tx_if.slave         axis,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in
`ifdef AXIS_FLIT_TX_STATS_EN
  ,
  output logic [31:0]           flit_count,
  output logic                  credit_err
`endif
);

  localparam int IW = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(SERIALIZATION_FACTOR - 1);
  localparam logic [CW-1:0] MAX_CREDIT = CW'(FLIT_BUFFER_DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          credit_cnt_q, credit_cnt_d;
  logic                   ready_en_q;
  logic [TDATA_WIDTH-1:0] data_q;
  logic [DEST_WIDTH-1:0]  dest_q;
  logic                   last_q;

  logic buf_valid;
  logic last_flit;
  logic send_now;
  logic accept;

  assign buf_valid = (state_q == SEND);
  assign last_flit = (idx_q == LAST_IDX);
  assign send_now  = buf_valid && (credit_cnt_q != '0);
  // ready_en_q keeps tready low through reset and for the first cycle after release.
  assign axis.axis_tready = ready_en_q && (!buf_valid || (send_now && last_flit));
  assign accept    = axis.axis_tvalid && axis.axis_tready;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (accept) state_d = SEND;
      SEND: if (send_now && last_flit && !accept) state_d = IDLE;
    endcase
    if (send_now) idx_d = last_flit ? '0 : idx_q + IW'(1);
  end

  always_comb begin
    credit_cnt_d = credit_cnt_q;
    case ({send_now, credit_in})
      2'b10:   credit_cnt_d = credit_cnt_q - CW'(1);
      2'b01:   if (credit_cnt_q != MAX_CREDIT) credit_cnt_d = credit_cnt_q + CW'(1);
      default: credit_cnt_d = credit_cnt_q;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      credit_cnt_q <= MAX_CREDIT;
      ready_en_q   <= 1'b0;
      send_out     <= 1'b0;
      is_tail_out  <= 1'b0;
      data_out     <= '0;
      dest_out     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      credit_cnt_q <= credit_cnt_d;
      ready_en_q   <= 1'b1;
      send_out     <= send_now;
      if (send_now) begin
        data_out    <= data_q[int'(idx_q) * FLIT_WIDTH +: FLIT_WIDTH];
        dest_out    <= dest_q;
        is_tail_out <= last_q && last_flit;
      end
    end
  end

  // NOTE: the payload register needs no reset; state qualifies it, so it stays plain flops.
  always_ff @(posedge clk_noc) begin
    if (accept) begin
      data_q <= axis.axis_tdata;
      dest_q <= axis.axis_tdest;
      last_q <= axis.axis_tlast;
    end
  end

`ifdef AXIS_FLIT_TX_STATS_EN
  logic credit_drop;
  assign credit_drop = credit_in && !send_now && (credit_cnt_q == MAX_CREDIT);

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      flit_count <= '0;
      credit_err <= 1'b0;
    end else begin
      if (send_now)    flit_count <= flit_count + 32'd1;
      if (credit_drop) credit_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_flit_tx.sv
// Scoreboard bench for axis_flit_tx: three instances (SF1/depth1, SF2/depth4, SF1/depth2).
module tb_axis_flit_tx;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  dest;
    logic        tail;
  } flit_t;

  logic clk_noc = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_noc = ~clk_noc;

  int cyc = 0;
  always @(posedge clk_noc) cyc <= cyc + 1;

  logic [2:0]  tv = '0, tl = '0, cr = '0;
  logic [31:0] td   [3];
  logic [3:0]  tdst [3];
  wire  [2:0]  rdy, snd, tail;
  wire  [31:0] d0, d2;
  wire  [15:0] d1;
  wire  [3:0]  dst0, dst1, dst2;

  axis_flit_tx_if #(.TDATA_WIDTH(32), .DEST_WIDTH(4)) if0 ();
  axis_flit_tx_if #(.TDATA_WIDTH(32), .DEST_WIDTH(4)) if1 ();
  axis_flit_tx_if #(.TDATA_WIDTH(32), .DEST_WIDTH(4)) if2 ();

  assign if0.axis_tvalid = tv[0]; assign if0.axis_tdata = td[0];
  assign if0.axis_tlast  = tl[0]; assign if0.axis_tdest = tdst[0];
  assign if1.axis_tvalid = tv[1]; assign if1.axis_tdata = td[1];
  assign if1.axis_tlast  = tl[1]; assign if1.axis_tdest = tdst[1];
  assign if2.axis_tvalid = tv[2]; assign if2.axis_tdata = td[2];
  assign if2.axis_tlast  = tl[2]; assign if2.axis_tdest = tdst[2];
  assign rdy[0] = if0.axis_tready;
  assign rdy[1] = if1.axis_tready;
  assign rdy[2] = if2.axis_tready;

`ifdef AXIS_FLIT_TX_STATS_EN
  wire [31:0] fc0, fc1, fc2;
  wire        ce0, ce1, ce2;
`endif

  axis_flit_tx #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(1)) u_dut0 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis(if0),
    .data_out(d0), .dest_out(dst0), .is_tail_out(tail[0]), .send_out(snd[0]), .credit_in(cr[0])
`ifdef AXIS_FLIT_TX_STATS_EN
    , .flit_count(fc0), .credit_err(ce0)
`endif
  );

  axis_flit_tx #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(2), .FLIT_BUFFER_DEPTH(4)) u_dut1 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis(if1),
    .data_out(d1), .dest_out(dst1), .is_tail_out(tail[1]), .send_out(snd[1]), .credit_in(cr[1])
`ifdef AXIS_FLIT_TX_STATS_EN
    , .flit_count(fc1), .credit_err(ce1)
`endif
  );

  axis_flit_tx #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2)) u_dut2 (
    .clk_noc(clk_noc), .rst_n(rst_n), .axis(if2),
    .data_out(d2), .dest_out(dst2), .is_tail_out(tail[2]), .send_out(snd[2]), .credit_in(cr[2])
`ifdef AXIS_FLIT_TX_STATS_EN
    , .flit_count(fc2), .credit_err(ce2)
`endif
  );

  int    checks = 0;
  int    errors = 0;
  flit_t exp_q    [3][$];
  int    send_cyc [3][$];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] dout(int i);
    case (i)
      0:       return d0;
      1:       return {16'h0, d1};
      default: return d2;
    endcase
  endfunction

  function automatic logic [3:0] dstout(int i);
    case (i)
      0:       return dst0;
      1:       return dst1;
      default: return dst2;
    endcase
  endfunction

  // Monitor: every send_out pulse pops one expected flit for that instance.
  always @(negedge clk_noc) begin
    flit_t e;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (snd[i]) begin
          send_cyc[i].push_back(cyc);
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d unexpected flit: data %0h expected none", i, dout(i));
          end else begin
            e = exp_q[i].pop_front();
            check($sformatf("dut%0d flit data", i), dout(i), e.data);
            check($sformatf("dut%0d flit dest", i), dstout(i), e.dest);
            check($sformatf("dut%0d flit tail", i), tail[i], e.tail);
          end
        end
      end
    end
  end

  task automatic expect_flit(int i, logic [31:0] d, logic [3:0] dest, logic t);
    flit_t e;
    e.data = d; e.dest = dest; e.tail = t;
    exp_q[i].push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk_noc); #1; end
  endtask

  // Holds the beat until it is accepted; returns one step after the accepting edge.
  task automatic put_beat(int i, logic [31:0] d, logic [3:0] dest, logic last);
    bit ok = 1'b0;
    tv[i] = 1'b1; td[i] = d; tdst[i] = dest; tl[i] = last;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk_noc);
      ok = rdy[i];
      @(posedge clk_noc); #1;
    end
    tv[i] = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL dut%0d beat accept timeout: data %0h", i, d);
    end
  endtask

  task automatic wait_flit(int i, int n, int budget);
    int k = 0;
    while (send_cyc[i].size() < n && k < budget) begin
      @(negedge clk_noc); #1;
      k++;
    end
    if (send_cyc[i].size() < n) begin
      checks++;
      errors++;
      $display("FAIL dut%0d flit %0d timeout: got %0d sends", i, n, send_cyc[i].size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin td[i] = '0; tdst[i] = '0; end

    // Reset values while rst_n is held low.
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d reset tready", i), rdy[i], 0);
      check($sformatf("dut%0d reset send_out", i), snd[i], 0);
    end
    check("dut0 reset data_out", d0, 0);
    check("dut0 reset dest_out", dst0, 0);
    check("dut0 reset tail", tail[0], 0);
    check("dut0 reset credit", u_dut0.credit_cnt_q, 1);
    check("dut1 reset credit", u_dut1.credit_cnt_q, 4);
    check("dut2 reset credit", u_dut2.credit_cnt_q, 2);

    @(posedge clk_noc); #3 rst_n = 1'b1;
    #1 check("tready low right after release", rdy[0], 0);
    tick(1);
    check("tready one cycle after release", rdy[0], 1);

    // SF=1 depth=1: back-to-back beats, credit returned two cycles after each send.
    expect_flit(0, 32'h1111_1111, 4'd3, 1'b0);
    expect_flit(0, 32'h2222_2222, 4'd5, 1'b1);
    fork
      begin
        put_beat(0, 32'h1111_1111, 4'd3, 1'b0);
        put_beat(0, 32'h2222_2222, 4'd5, 1'b1);
      end
      begin
        for (int k = 1; k <= 2; k++) begin
          wait_flit(0, k, 40);
          @(posedge clk_noc); #1 cr[0] = 1'b1;
          @(posedge clk_noc); #1 cr[0] = 1'b0;
        end
      end
    join
    check("dut0 send spacing", send_cyc[0][1] - send_cyc[0][0], 3);
    check("dut0 credit restored", u_dut0.credit_cnt_q, 1);

    // Zero credits with credit_in and a buffered beat in the same cycle.
    expect_flit(0, 32'h3333_3333, 4'd1, 1'b1);
    expect_flit(0, 32'h4444_4444, 4'd2, 1'b0);
    put_beat(0, 32'h3333_3333, 4'd1, 1'b1);
    put_beat(0, 32'h4444_4444, 4'd2, 1'b0);
    @(negedge clk_noc);
    check("dut0 stalled tready", rdy[0], 0);
    check("dut0 stalled credit", u_dut0.credit_cnt_q, 0);
    @(posedge clk_noc); #1 cr[0] = 1'b1;
    tick(1);
    cr[0] = 1'b0;
    @(negedge clk_noc);
    check("dut0 no send in credit cycle", snd[0], 0);
    @(posedge clk_noc); #1;
    @(negedge clk_noc);
    check("dut0 send after credit", snd[0], 1);
    check("dut0 credit after resend", u_dut0.credit_cnt_q, 0);

    // Saturation: the second credit at full count is dropped.
    @(posedge clk_noc); #1 cr[0] = 1'b1;
    tick(1);
    cr[0] = 1'b0;
    check("dut0 credit refill", u_dut0.credit_cnt_q, 1);
    cr[0] = 1'b1;
    tick(1);
    cr[0] = 1'b0;
    check("dut0 credit saturates", u_dut0.credit_cnt_q, 1);
`ifdef AXIS_FLIT_TX_STATS_EN
    check("dut0 credit_err", ce0, 1);
    check("dut0 flit_count", fc0, 4);
    check("dut1 credit_err clear", ce1, 0);
`endif

    // SF=2 depth=4: low half then high half, tready low during flit 0.
    expect_flit(1, 32'h0000_CCDD, 4'd7, 1'b0);
    expect_flit(1, 32'h0000_AABB, 4'd7, 1'b1);
    put_beat(1, 32'hAABB_CCDD, 4'd7, 1'b1);
    @(negedge clk_noc);
    check("dut1 tready during flit0", rdy[1], 0);
    @(posedge clk_noc); #1;
    @(negedge clk_noc);
    check("dut1 tready during flit1", rdy[1], 1);
    wait_flit(1, 2, 10);
    check("dut1 flit spacing", send_cyc[1][1] - send_cyc[1][0], 1);
    tick(2);

    // depth=2, no credits: third beat waits for one credit_in.
    expect_flit(2, 32'hA000_0001, 4'd1, 1'b1);
    expect_flit(2, 32'hA000_0002, 4'd2, 1'b1);
    expect_flit(2, 32'hA000_0003, 4'd3, 1'b1);
    put_beat(2, 32'hA000_0001, 4'd1, 1'b1);
    put_beat(2, 32'hA000_0002, 4'd2, 1'b1);
    put_beat(2, 32'hA000_0003, 4'd3, 1'b1);
    tick(3);
    check("dut2 sends before credit", send_cyc[2].size(), 2);
    @(negedge clk_noc);
    check("dut2 starved send_out", snd[2], 0);
    check("dut2 starved tready", rdy[2], 0);
    @(posedge clk_noc); #1 cr[2] = 1'b1;
    tick(1);
    cr[2] = 1'b0;
    @(negedge clk_noc);
    check("dut2 no send in credit cycle", snd[2], 0);
    @(posedge clk_noc); #1;
    @(negedge clk_noc);
    check("dut2 third send", snd[2], 1);
    tick(2);

    // Reset between flit 0 and flit 1: flit 1 must never appear.
    expect_flit(1, 32'h0000_5678, 4'd2, 1'b0);
    put_beat(1, 32'h1234_5678, 4'd2, 1'b1);
    @(posedge clk_noc);
    @(negedge clk_noc);
    #1 rst_n = 1'b0;
    #1;
    check("dut1 mid reset send_out", snd[1], 0);
    check("dut1 mid reset data_out", d1, 0);
    check("dut1 mid reset dest_out", dst1, 0);
    check("dut1 mid reset tail", tail[1], 0);
    check("dut1 mid reset tready", rdy[1], 0);
    check("dut1 mid reset credit", u_dut1.credit_cnt_q, 4);
    tick(2);
    @(posedge clk_noc); #3 rst_n = 1'b1;
    tick(6);
    check("dut1 tready after reset", rdy[1], 1);

    check("dut0 total sends", send_cyc[0].size(), 4);
    check("dut1 total sends", send_cyc[1].size(), 3);
    check("dut2 total sends", send_cyc[2].size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("dut%0d leftover expected flits", i), exp_q[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
